reg_write_arbiter: RTL and testbench

//  Round-robin write arbiter and sequencer for one shared WIDTH-bit register built from
//  D flip-flops with enable/reset/preset. Grants one of NUM_REQ requesters per write slot.

---
 rtl/reg_write_arbiter.sv | 146 ++++++++++++++
 tb/tb_reg_write_arbiter.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/reg_write_arbiter.sv
// Round-robin write arbiter/sequencer for a shared register: one write or preset per 2 cycles.
// Optional feature: define ARB_LOCK_EN to add the i_lock port (winner keeps priority while locked).
module reg_write_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic [NUM_REQ-1:0]       i_req,
  input  logic [NUM_REQ*WIDTH-1:0] i_data,
  input  logic                     i_preset_req,
`ifdef ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]       i_lock,
`endif
  output logic [NUM_REQ-1:0]       o_grant,
  output logic [NUM_REQ-1:0]       o_ack,
  output logic                     o_preset_ack,
  output logic                     o_reg_en,
  output logic [WIDTH-1:0]         o_reg_d,
  output logic                     o_reg_preset,
  output logic                     o_busy
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam logic [PTR_W:0]   NUM_REQ_W = NUM_REQ[PTR_W:0];
  localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_PRESET
  } state_t;

  state_t             r_state, w_state_next;
  logic [PTR_W-1:0]   r_ptr, w_ptr_next;
  logic [PTR_W-1:0]   r_win, w_win_next;
  logic [PTR_W-1:0]   w_win;
  logic               w_found;
  logic [PTR_W:0]     w_sum;
  logic               w_keep;

  logic [NUM_REQ-1:0] r_grant, w_grant_next;
  logic [NUM_REQ-1:0] r_ack, w_ack_next;
  logic               r_preset_ack, w_preset_ack_next;
  logic               r_reg_en, w_reg_en_next;
  logic [WIDTH-1:0]   r_reg_d, w_reg_d_next;
  logic               r_reg_preset, w_reg_preset_next;
  logic               r_busy, w_busy_next;

  logic [WIDTH-1:0]   w_data_arr [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_data_slice
    assign w_data_arr[gi] = i_data[gi*WIDTH +: WIDTH];
  end

`ifdef ARB_LOCK_EN
  assign w_keep = i_lock[r_win];
`else
  assign w_keep = 1'b0;
`endif

  // Scan offsets high to low so the last hit is the one closest to r_ptr.
  always_comb begin
    w_win   = '0;
    w_found = 1'b0;
    w_sum   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_sum = {1'b0, r_ptr} + (PTR_W+1)'(k);
      if (w_sum >= NUM_REQ_W) w_sum = w_sum - NUM_REQ_W;
      if (i_req[w_sum[PTR_W-1:0]]) begin
        w_win   = w_sum[PTR_W-1:0];
        w_found = 1'b1;
      end
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_ptr_next        = r_ptr;
    w_win_next        = r_win;
    w_grant_next      = '0;
    w_ack_next        = '0;
    w_preset_ack_next = 1'b0;
    w_reg_en_next     = 1'b0;
    w_reg_d_next      = r_reg_d;
    w_reg_preset_next = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_preset_req) begin
          w_state_next      = S_PRESET;
          w_preset_ack_next = 1'b1;
          w_reg_preset_next = 1'b1;
        end else if (w_found) begin
          w_state_next  = S_WRITE;
          w_win_next    = w_win;
          w_grant_next  = NUM_REQ'(1) << w_win;
          w_ack_next    = NUM_REQ'(1) << w_win;
          w_reg_en_next = 1'b1;
          w_reg_d_next  = w_data_arr[w_win];
        end
      end
      S_WRITE: begin
        w_state_next = S_IDLE;
        if (!w_keep) w_ptr_next = (r_win == LAST_IDX) ? '0 : r_win + PTR_W'(1);
      end
      S_PRESET: w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
    w_busy_next = (w_state_next != S_IDLE);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_ptr        <= '0;
      r_win        <= '0;
      r_grant      <= '0;
      r_ack        <= '0;
      r_preset_ack <= 1'b0;
      r_reg_en     <= 1'b0;
      r_reg_d      <= '0;
      r_reg_preset <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_ptr        <= w_ptr_next;
      r_win        <= w_win_next;
      r_grant      <= w_grant_next;
      r_ack        <= w_ack_next;
      r_preset_ack <= w_preset_ack_next;
      r_reg_en     <= w_reg_en_next;
      r_reg_d      <= w_reg_d_next;
      r_reg_preset <= w_reg_preset_next;
      r_busy       <= w_busy_next;
    end
  end

  assign o_grant      = r_grant;
  assign o_ack        = r_ack;
  assign o_preset_ack = r_preset_ack;
  assign o_reg_en     = r_reg_en;
  assign o_reg_d      = r_reg_d;
  assign o_reg_preset = r_reg_preset;
  assign o_busy       = r_busy;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter (NUM_REQ=4, WIDTH=32); lock scenario runs when ARB_LOCK_EN is defined.
module tb_reg_write_arbiter;

  localparam int N = 4;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req;
  logic [N*W-1:0] data;
  logic           preset_req;
  logic [N-1:0]   lock;
  logic [N-1:0]   grant, ack;
  logic           preset_ack, reg_en, reg_preset, busy;
  logic [W-1:0]   reg_d;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  reg_write_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_req        (req),
    .i_data       (data),
    .i_preset_req (preset_req),
`ifdef ARB_LOCK_EN
    .i_lock       (lock),
`endif
    .o_grant      (grant),
    .o_ack        (ack),
    .o_preset_ack (preset_ack),
    .o_reg_en     (reg_en),
    .o_reg_d      (reg_d),
    .o_reg_preset (reg_preset),
    .o_busy       (busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_data(input int i, input logic [W-1:0] v);
    data[i*W +: W] = v;
  endtask

  task automatic expect_write(input string tag, input int w, input logic [W-1:0] d);
    check({tag, ".grant"},  64'(grant), 64'(1 << w));
    check({tag, ".ack"},    64'(ack),   64'(1 << w));
    check({tag, ".reg_en"}, 64'(reg_en), 64'd1);
    check({tag, ".reg_d"},  64'(reg_d), 64'(d));
    check({tag, ".busy"},   64'(busy),  64'd1);
    check({tag, ".preset"}, 64'(reg_preset), 64'd0);
    $display("WRITE %s: grant=%b ack=%b reg_d=%h", tag, grant, ack, reg_d);
  endtask

  task automatic expect_idle(input string tag, input logic [W-1:0] d);
    check({tag, ".grant"},  64'(grant), 64'd0);
    check({tag, ".ack"},    64'(ack),   64'd0);
    check({tag, ".reg_en"}, 64'(reg_en), 64'd0);
    check({tag, ".reg_d"},  64'(reg_d), 64'(d));
    check({tag, ".busy"},   64'(busy),  64'd0);
    check({tag, ".preset"}, 64'(reg_preset), 64'd0);
    check({tag, ".pack"},   64'(preset_ack), 64'd0);
    $display("IDLE  %s: reg_d=%h", tag, reg_d);
  endtask

  initial begin
    reset = 1'b1; req = '0; data = '0; preset_req = 1'b0; lock = '0;
    repeat (2) @(negedge clk);
    expect_idle("reset", 32'h0);
    reset = 1'b0;

    // Full rotation with all four requesting
    for (int i = 0; i < N; i++) set_data(i, 32'(i + 1));
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); expect_write($sformatf("rot%0d", k), k % N, 32'((k % N) + 1));
      if (k == 4) req = '0;
      @(negedge clk); expect_idle($sformatf("rot%0d_gap", k), 32'((k % N) + 1));
    end

    // Reset in the middle of a write to req 2 (Ptr is 1 here)
    req = 4'b0100;
    @(negedge clk); expect_write("pre_abort", 2, 32'h3);
    #2 reset = 1'b1;
    #1 expect_idle("abort", 32'h0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0; req = 4'b0101;
    @(negedge clk); expect_write("after_rst", 0, 32'h1);
    @(negedge clk); expect_idle("after_rst_gap", 32'h1);
    @(negedge clk); expect_write("served_2", 2, 32'h3);
    req = 4'b1000;
    @(negedge clk); expect_idle("served_2_gap", 32'h3);

    // Req 3 alone: wraps Ptr to 0; prove it with a 1001 request afterwards
    @(negedge clk); expect_write("wrap_a", 3, 32'h4);
    @(negedge clk); expect_idle("wrap_a_gap", 32'h4);
    @(negedge clk); expect_write("wrap_b", 3, 32'h4);
    req = 4'b1001;
    @(negedge clk); expect_idle("wrap_b_gap", 32'h4);
    @(negedge clk); expect_write("ptr0", 0, 32'h1);
    req = '0;
    @(negedge clk); expect_idle("ptr0_gap", 32'h1);

    // Preset beats a simultaneous request
    preset_req = 1'b1; req = 4'b0010;
    @(negedge clk);
    check("preset.strobe", 64'(reg_preset), 64'd1);
    check("preset.ack",    64'(preset_ack), 64'd1);
    check("preset.reg_en", 64'(reg_en), 64'd0);
    check("preset.wr_ack", 64'(ack), 64'd0);
    check("preset.busy",   64'(busy), 64'd1);
    $display("PRESET: reg_preset=%b preset_ack=%b", reg_preset, preset_ack);
    preset_req = 1'b0;
    @(negedge clk); expect_idle("preset_gap", 32'h1);
    @(negedge clk); expect_write("post_preset", 1, 32'h2);
    req = '0;
    @(negedge clk); expect_idle("post_preset_gap", 32'h2);

    // Data changed while the write is in flight must not leak into reg_d
    set_data(2, 32'hAAAA_0001); req = 4'b0100;
    @(negedge clk); expect_write("hold", 2, 32'hAAAA_0001);
    set_data(2, 32'h5555_0002); req = '0;
    @(negedge clk); expect_idle("hold_gap", 32'hAAAA_0001);

`ifdef ARB_LOCK_EN
    // Ptr is 3: req 0 wins, then stays first while locked
    req = 4'b0011; lock = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); expect_write($sformatf("lock%0d", k), 0, 32'h1);
      if (k == 2) lock = '0;
      @(negedge clk); expect_idle($sformatf("lock%0d_gap", k), 32'h1);
    end
    @(negedge clk); expect_write("unlock", 1, 32'h2);
    req = '0;
    @(negedge clk); expect_idle("unlock_gap", 32'h2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
